// File: rtl/mem_port_arbiter.sv
// Single-master memory bus arbiter: fixed-priority MMU page-table reads over LSU
// accesses, one transaction at a time, with byte/half/word formatting and a bus timeout.
module mem_port_arbiter #(
   parameter int TIMEOUT = 256
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        mmu_rd_req,
   input  logic [31:0] mmu_addr,
   output logic [31:0] mmu_data,
   output logic        mmu_ready,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic        ls_unsigned,
   input  logic [33:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic [31:0] ls_rdata,
   output logic        ls_ready,
   output logic        ls_err,
   output logic        bus_req,
   output logic        bus_we,
   output logic [33:0] bus_addr,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_wdata,
   input  logic [31:0] bus_rdata,
   input  logic        bus_ack
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] MMU_BUS = 2'd1;
   localparam logic [1:0] LS_BUS  = 2'd2;
   localparam logic [1:0] DONE    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          busReq_q, busReq_d;
   logic          busWe_q, busWe_d;
   logic [33:0]   busAddr_q, busAddr_d;
   logic [3:0]    busWstrb_q, busWstrb_d;
   logic [31:0]   busWdata_q, busWdata_d;
   logic [31:0]   mmuData_q, mmuData_d;
   logic          mmuReady_q, mmuReady_d;
   logic [31:0]   lsRdata_q, lsRdata_d;
   logic          lsReady_q, lsReady_d;
   logic          lsErr_q, lsErr_d;
   logic [1:0]    lsOff_q, lsOff_d;
   logic [1:0]    lsSize_q, lsSize_d;
   logic          lsUns_q, lsUns_d;
   logic          lsWe_q, lsWe_d;

   logic          misaligned;
   logic [3:0]    strobe;
   logic [31:0]   wdataFmt;
   logic [31:0]   lane;
   logic [31:0]   loadData;

   always_comb begin
      misaligned = (ls_size == 2'd3) ||
                   ((ls_size == 2'd2) && (ls_addr[1:0] != 2'b00)) ||
                   ((ls_size == 2'd1) && ls_addr[0]);
      case (ls_size)
         2'd0:    strobe = 4'b0001 << ls_addr[1:0];
         2'd1:    strobe = 4'b0011 << ls_addr[1:0];
         default: strobe = 4'hF;
      endcase
      case (ls_size)
         2'd0:    wdataFmt = {4{ls_wdata[7:0]}};
         2'd1:    wdataFmt = {2{ls_wdata[15:0]}};
         default: wdataFmt = ls_wdata;
      endcase
   end

   // Load lane selection uses the offset/size captured at grant, since the LSU may drop its request.
   always_comb begin
      lane = bus_rdata >> {lsOff_q, 3'b000};
      case (lsSize_q)
         2'd0:    loadData = lsUns_q ? {24'b0, lane[7:0]} : {{24{lane[7]}}, lane[7:0]};
         2'd1:    loadData = lsUns_q ? {16'b0, lane[15:0]} : {{16{lane[15]}}, lane[15:0]};
         default: loadData = bus_rdata;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      busReq_d   = busReq_q;
      busWe_d    = busWe_q;
      busAddr_d  = busAddr_q;
      busWstrb_d = busWstrb_q;
      busWdata_d = busWdata_q;
      mmuData_d  = mmuData_q;
      mmuReady_d = 1'b0;
      lsRdata_d  = lsRdata_q;
      lsReady_d  = 1'b0;
      lsErr_d    = 1'b0;
      lsOff_d    = lsOff_q;
      lsSize_d   = lsSize_q;
      lsUns_d    = lsUns_q;
      lsWe_d     = lsWe_q;
      case (state_q)
         IDLE: begin
            if (mmu_rd_req) begin
               state_d    = MMU_BUS;
               timer_d    = '0;
               busReq_d   = 1'b1;
               busWe_d    = 1'b0;
               busAddr_d  = {2'b00, mmu_addr};
               busWstrb_d = 4'hF;
            end else if (ls_req && misaligned) begin
               state_d   = DONE;
               lsRdata_d = '0;
               lsReady_d = 1'b1;
               lsErr_d   = 1'b1;
            end else if (ls_req) begin
               state_d    = LS_BUS;
               timer_d    = '0;
               busReq_d   = 1'b1;
               busWe_d    = ls_we;
               busAddr_d  = {ls_addr[33:2], 2'b00};
               busWstrb_d = strobe;
               busWdata_d = wdataFmt;
               lsOff_d    = ls_addr[1:0];
               lsSize_d   = ls_size;
               lsUns_d    = ls_unsigned;
               lsWe_d     = ls_we;
            end
         end
         MMU_BUS: begin
            if (bus_ack) begin
               state_d    = DONE;
               busReq_d   = 1'b0;
               mmuData_d  = bus_rdata;
               mmuReady_d = 1'b1;
            end else if (timer_q == TLAST) begin
               // Zero data on timeout leaves V=0, so the MMU raises a page fault.
               state_d    = DONE;
               busReq_d   = 1'b0;
               mmuData_d  = '0;
               mmuReady_d = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         LS_BUS: begin
            if (bus_ack) begin
               state_d   = DONE;
               busReq_d  = 1'b0;
               lsRdata_d = lsWe_q ? 32'b0 : loadData;
               lsReady_d = 1'b1;
            end else if (timer_q == TLAST) begin
               state_d   = DONE;
               busReq_d  = 1'b0;
               lsRdata_d = '0;
               lsReady_d = 1'b1;
               lsErr_d   = 1'b1;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         busReq_q   <= 1'b0;
         busWe_q    <= 1'b0;
         busAddr_q  <= '0;
         busWstrb_q <= '0;
         busWdata_q <= '0;
         mmuData_q  <= '0;
         mmuReady_q <= 1'b0;
         lsRdata_q  <= '0;
         lsReady_q  <= 1'b0;
         lsErr_q    <= 1'b0;
         lsOff_q    <= '0;
         lsSize_q   <= '0;
         lsUns_q    <= 1'b0;
         lsWe_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         busReq_q   <= busReq_d;
         busWe_q    <= busWe_d;
         busAddr_q  <= busAddr_d;
         busWstrb_q <= busWstrb_d;
         busWdata_q <= busWdata_d;
         mmuData_q  <= mmuData_d;
         mmuReady_q <= mmuReady_d;
         lsRdata_q  <= lsRdata_d;
         lsReady_q  <= lsReady_d;
         lsErr_q    <= lsErr_d;
         lsOff_q    <= lsOff_d;
         lsSize_q   <= lsSize_d;
         lsUns_q    <= lsUns_d;
         lsWe_q     <= lsWe_d;
      end
   end

   assign mmu_data  = mmuData_q;
   assign mmu_ready = mmuReady_q;
   assign ls_rdata  = lsRdata_q;
   assign ls_ready  = lsReady_q;
   assign ls_err    = lsErr_q;
   assign bus_req   = busReq_q;
   assign bus_we    = busWe_q;
   assign bus_addr  = busAddr_q;
   assign bus_wstrb = busWstrb_q;
   assign bus_wdata = busWdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized LSU/MMU traffic,
// with expectations derived from byte-level arithmetic on the access rules.
module tb_mem_port_arbiter;

   localparam int TIMEOUT = 256;

   logic        clk = 1'b0;
   logic        reset;
   logic        mmu_rd_req;
   logic [31:0] mmu_addr;
   logic [31:0] mmu_data;
   logic        mmu_ready;
   logic        ls_req;
   logic        ls_we;
   logic [1:0]  ls_size;
   logic        ls_unsigned;
   logic [33:0] ls_addr;
   logic [31:0] ls_wdata;
   logic [31:0] ls_rdata;
   logic        ls_ready;
   logic        ls_err;
   logic        bus_req;
   logic        bus_we;
   logic [33:0] bus_addr;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_wdata;
   logic [31:0] bus_rdata;
   logic        bus_ack;

   int checks = 0;
   int errors = 0;

   mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset),
      .mmu_rd_req(mmu_rd_req), .mmu_addr(mmu_addr), .mmu_data(mmu_data), .mmu_ready(mmu_ready),
      .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_unsigned(ls_unsigned),
      .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_rdata(ls_rdata), .ls_ready(ls_ready),
      .ls_err(ls_err), .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int nBytes(input logic [1:0] size);
      return 1 << size;
   endfunction

   function automatic bit modelMisaligned(input logic [1:0] size, input logic [33:0] addr);
      if (size == 2'd3) return 1'b1;
      return (int'(addr[1:0]) % nBytes(size)) != 0;
   endfunction

   function automatic logic [3:0] modelStrobe(input logic [1:0] size, input logic [33:0] addr);
      int mask = (1 << nBytes(size)) - 1;
      return 4'(mask << int'(addr[1:0]));
   endfunction

   function automatic logic [31:0] modelWdata(input logic [1:0] size, input logic [31:0] wd);
      if (size == 2'd0) return {24'b0, wd[7:0]} * 32'h0101_0101;
      if (size == 2'd1) return {16'b0, wd[15:0]} * 32'h0001_0001;
      return wd;
   endfunction

   // Pick the addressed bytes, then sign-extend by subtracting 2^bits when the top bit is set.
   function automatic logic [31:0] modelLoad(input logic [1:0] size, input bit uns,
                                             input logic [33:0] addr, input logic [31:0] rd);
      logic [63:0] v;
      int bits;
      if (size == 2'd2) return rd;
      bits = 8 * nBytes(size);
      v = ({32'b0, rd} >> (8 * int'(addr[1:0]))) & ((64'd1 << bits) - 1);
      if (!uns && v >= (64'd1 << (bits - 1))) v = v + 64'h1_0000_0000 - (64'd1 << bits);
      return v[31:0];
   endfunction

   task automatic lsAccess(input bit we, input logic [1:0] size, input bit uns,
                           input logic [33:0] addr, input logic [31:0] wd,
                           input logic [31:0] rd, input int delay);
      ls_req = 1'b1; ls_we = we; ls_size = size; ls_unsigned = uns;
      ls_addr = addr; ls_wdata = wd;
      if (modelMisaligned(size, addr)) begin
         @(negedge clk);
         checkOutput("misalign_ready", ls_ready, 1);
         checkOutput("misalign_err", ls_err, 1);
         checkOutput("misalign_noreq", bus_req, 0);
         ls_req = 1'b0;
         @(negedge clk);
         checkOutput("misalign_pulse", ls_ready, 0);
         checkOutput("misalign_noreq2", bus_req, 0);
         return;
      end
      @(negedge clk);
      checkOutput("ls_bus_req", bus_req, 1);
      checkOutput("ls_bus_we", bus_we, we);
      checkOutput("ls_bus_addr", bus_addr, {addr[33:2], 2'b00});
      if (we) begin
         checkOutput("ls_wstrb", bus_wstrb, modelStrobe(size, addr));
         checkOutput("ls_wdata", bus_wdata, modelWdata(size, wd));
      end
      repeat (delay) @(negedge clk);
      checkOutput("ls_ready_early", ls_ready, 0);
      bus_ack = 1'b1; bus_rdata = rd;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      checkOutput("ls_ready", ls_ready, 1);
      checkOutput("ls_err", ls_err, 0);
      checkOutput("ls_rdata", ls_rdata, we ? 32'b0 : modelLoad(size, uns, addr, rd));
      checkOutput("ls_req_drop", bus_req, 0);
      ls_req = 1'b0;
      @(negedge clk);
      checkOutput("ls_pulse", ls_ready, 0);
   endtask

   task automatic mmuAccess(input logic [31:0] addr, input logic [31:0] rd, input int delay);
      mmu_rd_req = 1'b1; mmu_addr = addr;
      @(negedge clk);
      checkOutput("mmu_bus_req", bus_req, 1);
      checkOutput("mmu_bus_we", bus_we, 0);
      checkOutput("mmu_bus_addr", bus_addr, {2'b00, addr});
      checkOutput("mmu_wstrb", bus_wstrb, 4'hF);
      repeat (delay) @(negedge clk);
      bus_ack = 1'b1; bus_rdata = rd;
      @(negedge clk);
      bus_ack = 1'b0; bus_rdata = $urandom;
      checkOutput("mmu_ready", mmu_ready, 1);
      checkOutput("mmu_data", mmu_data, rd);
      checkOutput("mmu_req_drop", bus_req, 0);
      mmu_rd_req = 1'b0;
      @(negedge clk);
      checkOutput("mmu_pulse", mmu_ready, 0);
   endtask

   task automatic timeoutRun(input bit isMmu);
      int cycles = 0;
      if (isMmu) begin
         mmu_rd_req = 1'b1; mmu_addr = 32'h0000_4000;
      end else begin
         ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 34'h1_0000_0010;
      end
      @(negedge clk);
      while (bus_req && cycles < TIMEOUT + 20) begin
         cycles++;
         @(negedge clk);
      end
      checkOutput("to_cycles", cycles, TIMEOUT);
      if (isMmu) begin
         checkOutput("to_mmu_ready", mmu_ready, 1);
         checkOutput("to_mmu_data", mmu_data, 0);
      end else begin
         checkOutput("to_ls_ready", ls_ready, 1);
         checkOutput("to_ls_err", ls_err, 1);
      end
      mmu_rd_req = 1'b0; ls_req = 1'b0;
      @(negedge clk);
      checkOutput("to_pulse", mmu_ready | ls_ready, 0);
   endtask

   task automatic applyStimulus();
      logic [33:0] ra;
      bit          pickMmu;
      // Reset state
      reset = 1'b1; mmu_rd_req = 0; mmu_addr = 0; ls_req = 0; ls_we = 0; ls_size = 0;
      ls_unsigned = 0; ls_addr = 0; ls_wdata = 0; bus_rdata = 0; bus_ack = 0;
      repeat (2) @(negedge clk);
      checkOutput("rst_bus_req", bus_req, 0);
      checkOutput("rst_readies", {mmu_ready, ls_ready, ls_err}, 0);
      checkOutput("rst_bus_addr", bus_addr, 0);
      reset = 1'b0;
      @(negedge clk);

      mmuAccess(32'h8000_1004, 32'h2000_040F, 3);

      // Simultaneous requests: MMU first, LSU granted only after DONE
      mmu_rd_req = 1'b1; mmu_addr = 32'h0000_0100;
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_unsigned = 1'b0; ls_addr = 34'h2_0000_0200;
      @(negedge clk);
      checkOutput("sim_mmu_addr", bus_addr, 34'h0_0000_0100);
      checkOutput("sim_mmu_we", bus_we, 0);
      bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
      @(negedge clk);
      bus_ack = 1'b0;
      checkOutput("sim_mmu_ready", mmu_ready, 1);
      checkOutput("sim_ls_wait", ls_ready, 0);
      checkOutput("sim_done_noreq", bus_req, 0);
      mmu_rd_req = 1'b0;
      @(negedge clk);
      checkOutput("sim_idle_noreq", bus_req, 0);
      checkOutput("sim_mmu_once", mmu_ready, 0);
      @(negedge clk);
      checkOutput("sim_ls_req", bus_req, 1);
      checkOutput("sim_ls_addr", bus_addr, 34'h2_0000_0200);
      bus_ack = 1'b1; bus_rdata = 32'h3333_4444;
      @(negedge clk);
      bus_ack = 1'b0;
      checkOutput("sim_ls_ready", ls_ready, 1);
      checkOutput("sim_ls_rdata", ls_rdata, 32'h3333_4444);
      checkOutput("sim_no_mmu", mmu_ready, 0);
      ls_req = 1'b0;
      @(negedge clk);
      checkOutput("sim_ls_once", ls_ready, 0);

      lsAccess(1'b1, 2'd0, 1'b0, 34'h3_0000_0003, 32'h0000_00A5, 32'h0, 0);
      lsAccess(1'b0, 2'd1, 1'b0, 34'h1_2345_6782, 32'h0, 32'h8001_0000, 1);
      lsAccess(1'b0, 2'd2, 1'b0, 34'h0_0000_1006, 32'h0, 32'h0, 0);

      timeoutRun(1'b1);
      timeoutRun(1'b0);

      // Reset while in LS_BUS aborts silently
      ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'd2; ls_addr = 34'h0_0000_0040;
      @(negedge clk);
      checkOutput("abort_granted", bus_req, 1);
      reset = 1'b1;
      #1;
      checkOutput("abort_outputs", {bus_req, bus_we, bus_wstrb, ls_ready, ls_err, mmu_ready}, 0);
      checkOutput("abort_addr", bus_addr, 0);
      ls_req = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("abort_quiet", {ls_ready, bus_req}, 0);
      end
      lsAccess(1'b0, 2'd0, 1'b1, 34'h0_0000_0041, 32'h0, 32'hDEAD_BEEF, 2);

      // Randomized mixed traffic
      for (int i = 0; i < 60; i++) begin
         pickMmu = ($urandom_range(0, 4) == 0);
         ra = {$urandom, $urandom};
         if (pickMmu)
            mmuAccess({ra[31:2], 2'b00}, $urandom, $urandom_range(0, 3));
         else
            lsAccess(1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom), ra,
                     $urandom, $urandom, $urandom_range(0, 3));
      end
   endtask

   initial begin
      applyStimulus();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "[TB] watchdog");
   end

endmodule
